alu_issue_ctrl: RTL and testbench

- Clocked front-end that drives the combinational signed ALU (alu_s).
- Accepts operation requests over a valid/ready handshake and buffers them in a small FIFO.
- Presents each request to the ALU, waits a fixed settle window, captures output1/output2, and returns them over a valid/ready response handshake.
- Screens invalid opcodes and divide-by-zero before they reach the ALU.

---
 rtl/alu_issue_ctrl.sv | 109 ++++++++++
 tb/tb_alu_issue_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: queues ALU requests in a FIFO, drives alu_s for a settle window and returns its results.
// Invalid opcodes and divide-by-zero are answered directly without touching the ALU inputs.
module alu_issue_ctrl #(
    parameter int SIZE   = 32,
    parameter int DEPTH  = 4,
    parameter int SETTLE = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic [2:0]        i_req_op,
    input  logic [SIZE-1:0]   i_req_a,
    input  logic [SIZE-1:0]   i_req_b,
    output logic              o_resp_valid,
    input  logic              i_resp_ready,
    output logic [2*SIZE-1:0] o_resp_lo,
    output logic [2*SIZE-1:0] o_resp_hi,
    output logic              o_resp_err,
    output logic [2:0]        o_alu_control,
    output logic [SIZE-1:0]   o_alu_num1,
    output logic [SIZE-1:0]   o_alu_num2,
    input  logic [2*SIZE-1:0] i_alu_output1,
    input  logic [2*SIZE-1:0] i_alu_output2
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(SETTLE + 1);
    localparam logic [1:0] S_IDLE = 2'd0, S_WAIT = 2'd1, S_RESP = 2'd2;

    logic [2:0]      r_op [DEPTH];
    logic [SIZE-1:0] r_a  [DEPTH];
    logic [SIZE-1:0] r_b  [DEPTH];
    logic [AW:0]     r_wp, r_rp;
    logic [1:0]      r_state;
    logic [CW-1:0]   r_cnt;

    logic            w_full, w_empty, w_push, w_pop, w_err;
    logic [2:0]      w_op;
    logic [SIZE-1:0] w_a, w_b;

    // Extra wrap bit distinguishes full from empty when the index bits match.
    assign w_full      = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
    assign w_empty     = r_wp == r_rp;
    assign o_req_ready = !w_full;
    assign w_push      = i_req_valid && !w_full;
    assign w_pop       = (r_state == S_IDLE) && !w_empty;
    assign w_op        = r_op[r_rp[AW-1:0]];
    assign w_a         = r_a[r_rp[AW-1:0]];
    assign w_b         = r_b[r_rp[AW-1:0]];
    assign w_err       = (w_op == 3'b111) || (w_op == 3'b011 && w_b == '0);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_op[r_wp[AW-1:0]] <= i_req_op;
            r_a[r_wp[AW-1:0]]  <= i_req_a;
            r_b[r_wp[AW-1:0]]  <= i_req_b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wp <= '0;
            r_rp <= '0;
        end else begin
            if (w_push) r_wp <= r_wp + (AW+1)'(1);
            if (w_pop) r_rp <= r_rp + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            o_resp_valid  <= 1'b0;
            o_resp_err    <= 1'b0;
            o_resp_lo     <= '0;
            o_resp_hi     <= '0;
            o_alu_control <= '0;
            o_alu_num1    <= '0;
            o_alu_num2    <= '0;
        end else if (r_state == S_IDLE) begin
            if (w_pop && w_err) begin
                o_resp_lo    <= '0;
                o_resp_hi    <= '0;
                o_resp_err   <= 1'b1;
                o_resp_valid <= 1'b1;
                r_state      <= S_RESP;
            end else if (w_pop) begin
                o_alu_control <= w_op;
                o_alu_num1    <= w_a;
                o_alu_num2    <= w_b;
                r_cnt         <= CW'(SETTLE);
                r_state       <= S_WAIT;
            end
        end else if (r_state == S_WAIT) begin
            r_cnt <= r_cnt - CW'(1);
            if (r_cnt == CW'(1)) begin
                o_resp_lo    <= i_alu_output1;
                o_resp_hi    <= i_alu_output2;
                o_resp_err   <= 1'b0;
                o_resp_valid <= 1'b1;
                r_state      <= S_RESP;
            end
        end else if (i_resp_ready) begin
            o_resp_valid <= 1'b0;
            r_state      <= S_IDLE;
        end
    end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed and randomized checks of alu_issue_ctrl against a signed ALU model.
// The bench also stands in for alu_s, computing its outputs from the DUT's ALU-side ports.
module tb_alu_issue_ctrl;
    localparam int SETTLE = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        i_req_valid = 1'b0;
    logic        o_req_ready;
    logic [2:0]  i_req_op = '0;
    logic [31:0] i_req_a = '0;
    logic [31:0] i_req_b = '0;
    logic        o_resp_valid;
    logic        i_resp_ready = 1'b0;
    logic [63:0] o_resp_lo, o_resp_hi;
    logic        o_resp_err;
    logic [2:0]  o_alu_control;
    logic [31:0] o_alu_num1, o_alu_num2;
    logic [63:0] i_alu_output1, i_alu_output2;

    int checks = 0;
    int errors = 0;
    logic [128:0] q[$];

    alu_issue_ctrl #(.SIZE(32), .DEPTH(4), .SETTLE(SETTLE)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_req_op(i_req_op), .i_req_a(i_req_a), .i_req_b(i_req_b),
        .o_resp_valid(o_resp_valid), .i_resp_ready(i_resp_ready),
        .o_resp_lo(o_resp_lo), .o_resp_hi(o_resp_hi), .o_resp_err(o_resp_err),
        .o_alu_control(o_alu_control), .o_alu_num1(o_alu_num1), .o_alu_num2(o_alu_num2),
        .i_alu_output1(i_alu_output1), .i_alu_output2(i_alu_output2)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] alu_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] ea, eb, lo, hi;
        ea = $signed(a);
        eb = $signed(b);
        hi = '0;
        case (op)
            3'd0: lo = ea + eb;
            3'd1: lo = ea - eb;
            3'd2: lo = ea * eb;
            3'd3: begin
                lo = (eb == 0) ? 64'sd0 : ea / eb;
                hi = (eb == 0) ? 64'sd0 : ea % eb;
            end
            3'd4: lo = ~ea;
            3'd5: lo = ea & eb;
            3'd6: lo = ea | eb;
            default: lo = '0;
        endcase
        return {hi, lo};
    endfunction

    function automatic logic [128:0] ref_resp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op == 3'b111 || (op == 3'b011 && b == 32'd0)) return {1'b1, 128'd0};
        return {1'b0, alu_model(op, a, b)};
    endfunction

    always_comb {i_alu_output2, i_alu_output1} = alu_model(o_alu_control, o_alu_num1, o_alu_num2);

    task automatic chk(input string tag, input logic [191:0] got, input logic [191:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Push one op into an idle, empty DUT and check latency, result and ALU-side registers.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] elo, input logic [63:0] ehi, input logic eerr);
        int lat;
        logic [66:0] prev;
        lat = eerr ? 1 : SETTLE + 1;
        prev = {o_alu_control, o_alu_num1, o_alu_num2};
        i_req_op = op;
        i_req_a = a;
        i_req_b = b;
        i_req_valid = 1'b1;
        tick;
        i_req_valid = 1'b0;
        for (int k = 0; k < lat; k++) begin
            chk({tag, "_early"}, o_resp_valid, 0);
            tick;
        end
        chk({tag, "_valid"}, o_resp_valid, 1);
        chk({tag, "_lo"}, o_resp_lo, elo);
        chk({tag, "_hi"}, o_resp_hi, ehi);
        chk({tag, "_err"}, o_resp_err, eerr);
        chk({tag, "_alu"}, {o_alu_control, o_alu_num1, o_alu_num2}, eerr ? prev : {op, a, b});
        i_resp_ready = 1'b1;
        tick;
        i_resp_ready = 1'b0;
        chk({tag, "_taken"}, o_resp_valid, 0);
    endtask

    task automatic drain(input string tag, input int n);
        logic [128:0] e;
        for (int i = 0; i < n; i++) begin
            for (int w = 0; w < 100 && !o_resp_valid; w++) tick;
            if (!o_resp_valid) begin
                chk({tag, "_timeout"}, o_resp_valid, 1);
                return;
            end
            e = q.pop_front();
            chk(tag, {o_resp_err, o_resp_hi, o_resp_lo}, e);
            i_resp_ready = 1'b1;
            tick;
            i_resp_ready = 1'b0;
        end
    endtask

    initial begin
        logic [128:0] e;
        logic [2:0] op;
        logic [31:0] a, b;
        int sent, got, cyc;

        #2 rst_n = 1'b0;
        #1;
        chk("rst_ready", o_req_ready, 1);
        chk("rst_resp", {o_resp_valid, o_resp_err, o_resp_lo, o_resp_hi}, 0);
        chk("rst_alu", {o_alu_control, o_alu_num1, o_alu_num2}, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick;

        run_op("add", 3'b000, 32'd5, -32'sd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'd0, 1'b0);
        run_op("div", 3'b011, -32'sd17, 32'd5, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
        run_op("div0", 3'b011, 32'd9, 32'd0, 64'd0, 64'd0, 1'b1);
        run_op("mul", 3'b010, 32'h7FFF_FFFF, 32'd2, 64'h0000_0000_FFFF_FFFE, 64'd0, 1'b0);
        run_op("bad", 3'b111, 32'd1, 32'd2, 64'd0, 64'd0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            op = (i == 0) ? 3'd1 : 3'(i + 3);
            a = $urandom;
            b = $urandom;
            e = ref_resp(op, a, b);
            run_op("misc", op, a, b, e[63:0], e[127:64], e[128]);
        end

        // Backpressure: five pushes with the consumer stalled fill the 4-entry FIFO.
        q.delete();
        for (int i = 0; i < 5; i++) begin
            chk("bp_ready_before", o_req_ready, 1);
            i_req_op = 3'($urandom_range(0, 6));
            i_req_a = $urandom;
            i_req_b = $urandom | 32'd1;
            i_req_valid = 1'b1;
            q.push_back(ref_resp(i_req_op, i_req_a, i_req_b));
            tick;
        end
        i_req_valid = 1'b0;
        chk("bp_full", o_req_ready, 0);
        chk("bp_first_valid", o_resp_valid, 1);
        e = q.pop_front();
        chk("bp_first", {o_resp_err, o_resp_hi, o_resp_lo}, e);
        i_resp_ready = 1'b1;
        tick;
        i_resp_ready = 1'b0;
        chk("bp_no_pop_on_take", o_req_ready, 0);
        chk("bp_taken", o_resp_valid, 0);
        tick;
        chk("bp_ready_after_pop", o_req_ready, 1);
        drain("bp_resp", 4);

        // Async reset while an op is in WAIT and two more are queued.
        for (int i = 0; i < 3; i++) begin
            i_req_op = 3'b000;
            i_req_a = 32'(100 + i);
            i_req_b = 32'd3;
            i_req_valid = 1'b1;
            tick;
        end
        i_req_valid = 1'b0;
        chk("ar_inflight", o_alu_num1, 100);
        rst_n = 1'b0;
        #1;
        chk("ar_ready", o_req_ready, 1);
        chk("ar_resp", {o_resp_valid, o_resp_err, o_resp_lo, o_resp_hi}, 0);
        chk("ar_alu", {o_alu_control, o_alu_num1, o_alu_num2}, 0);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick;
            chk("ar_no_resp", o_resp_valid, 0);
        end
        run_op("ar_after", 3'b001, 32'd10, 32'd3, 64'd7, 64'd0, 1'b0);

        // Random traffic with random handshakes against the in-order scoreboard.
        q.delete();
        sent = 0;
        got = 0;
        cyc = 0;
        while ((sent < 200 || q.size() > 0) && cyc < 8000) begin
            i_req_valid = (sent < 200) && ($urandom_range(0, 3) != 0);
            i_req_op = 3'($urandom_range(0, 7));
            i_req_a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) - 32'd10 : $urandom;
            i_req_b = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            i_resp_ready = $urandom_range(0, 1) == 1;
            if (o_resp_valid && i_resp_ready) begin
                if (q.size() == 0) chk("rnd_extra", o_resp_valid, 0);
                else begin
                    e = q.pop_front();
                    chk("rnd_resp", {o_resp_err, o_resp_hi, o_resp_lo}, e);
                    got++;
                end
            end
            if (i_req_valid && o_req_ready) begin
                q.push_back(ref_resp(i_req_op, i_req_a, i_req_b));
                sent++;
            end
            tick;
            cyc++;
        end
        i_req_valid = 1'b0;
        chk("rnd_count", got, 200);
        chk("rnd_left", q.size(), 0);
        i_resp_ready = 1'b1;
        repeat (6) tick;
        chk("rnd_no_dup", o_resp_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
